sysid_boot_checker: RTL and testbench



---
 rtl/sysid_check_pkg.sv | 19 +
 rtl/sysid_wait_timer.sv | 40 ++++
 rtl/sysid_boot_checker.sv | 184 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system ID boot checker.
package sysid_check_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned TIMER_W = 16;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/sysid_wait_timer.sv
// Counts consecutive stalled read cycles and flags when the limit is reached.
// Only instantiated when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_wait_timer
    import sysid_check_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear wins, otherwise advance on each stalled cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the LIMIT-th consecutive stalled cycle so the read drops right after it.
    assign expire_c_o = enable_i && (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sequencer: reads system ID (word 0) and build timestamp (word 1),
// compares against expected values with bounded retries, and holds a sticky result.
// Optional stall timeout enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1464758967,
    parameter int unsigned       MAX_RETRIES    = 3,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               id_mismatch,
    output logic               ts_mismatch,
    output logic               timeout,
    output logic [DATA_W-1:0]  id_value,
    output logic [DATA_W-1:0]  ts_value,
    output logic [RETRY_W-1:0] retry_count
);

    // Reject parameter values the counters cannot represent.
    if (MAX_RETRIES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("sysid_boot_checker: parameter out of range");
    end

    state_e               state_q;
    logic                 boot_q;
    logic                 avm_read_q;
    logic                 avm_address_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 id_mismatch_q;
    logic                 ts_mismatch_q;
    logic [DATA_W-1:0]    id_value_q;
    logic [DATA_W-1:0]    ts_value_q;
    logic [RETRY_W-1:0]   retry_q;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic timeout_q;
    logic stall_c;
    logic expire_c;

    assign stall_c = avm_read_q && avm_waitrequest;

    sysid_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .clear_i    (!stall_c),
        .enable_i   (stall_c),
        .expire_c_o (expire_c)
    );
`endif

    // Sequencer: boot/manual launch, two reads, compare, retry, completion pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            boot_q        <= 1'b1;
            avm_read_q    <= 1'b0;
            avm_address_q <= SYSID_ADDR_ID;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_mismatch_q <= 1'b0;
            ts_mismatch_q <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
            retry_q       <= '0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (boot_q || start) begin
                        boot_q        <= 1'b0;
                        state_q       <= RD_ID;
                        avm_read_q    <= 1'b1;
                        avm_address_q <= SYSID_ADDR_ID;
                        busy_q        <= 1'b1;
                        pass_q        <= 1'b0;
                        id_mismatch_q <= 1'b0;
                        ts_mismatch_q <= 1'b0;
                        retry_q       <= '0;
`ifdef SYSID_CHECK_TIMEOUT_EN
                        timeout_q     <= 1'b0;
`endif
                    end
                end
                RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value_q    <= avm_readdata;
                        avm_address_q <= SYSID_ADDR_TS;
                        state_q       <= RD_TS;
                    end
`ifdef SYSID_CHECK_TIMEOUT_EN
                    else if (expire_c) begin
                        avm_read_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
`endif
                end
                RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value_q <= avm_readdata;
                        avm_read_q <= 1'b0;
                        state_q    <= CHECK;
                    end
`ifdef SYSID_CHECK_TIMEOUT_EN
                    else if (expire_c) begin
                        avm_read_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
`endif
                end
                CHECK: begin
                    if ((id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS)) begin
                        pass_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                        retry_q       <= retry_q + RETRY_W'(1);
                        avm_read_q    <= 1'b1;
                        avm_address_q <= SYSID_ADDR_ID;
                        state_q       <= RD_ID;
                    end else begin
                        id_mismatch_q <= (id_value_q != EXPECTED_ID);
                        ts_mismatch_q <= (ts_value_q != EXPECTED_TS);
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    avm_read_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mismatch_q;
    assign ts_mismatch = ts_mismatch_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign retry_count = retry_q;
`ifdef SYSID_CHECK_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized bench for sysid_boot_checker with a transaction-level result/latency model.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1464758967;
    localparam int          MAXR   = 3;
    localparam int          TMO    = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;
    logic [3:0]  retry_count;

    always #5 clock = ~clock;

    sysid_boot_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .MAX_RETRIES    (MAXR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_mismatch     (id_mismatch),
        .ts_mismatch     (ts_mismatch),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .retry_count     (retry_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int          rd_idx, run_base, stall_left, stall_cfg;
    bit          stuck;
    int          id_err, ts_err;
    logic [31:0] id_bad, ts_bad;

    // Pass n returns a bad ID while n < ie and a bad timestamp while n < te.
    function automatic logic [31:0] slave_word(input int rel, input int ie, input int te,
                                               input logic [31:0] ib, input logic [31:0] tb_);
        int p;
        p = rel / 2;
        if ((rel % 2) == 0) return (p < ie) ? ib : EXP_ID;
        return (p < te) ? tb_ : EXP_TS;
    endfunction

    assign avm_readdata    = slave_word(rd_idx - run_base, id_err, ts_err, id_bad, ts_bad);
    assign avm_waitrequest = stuck || (avm_read && stall_left != 0);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx     <= 0;
            stall_left <= stall_cfg;
        end else if (!avm_read) begin
            stall_left <= stall_cfg;
        end else if (!avm_waitrequest) begin
            rd_idx     <= rd_idx + 1;
            stall_left <= stall_cfg;
        end else if (stall_left != 0) begin
            stall_left <= stall_left - 1;
        end
    end

    int cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- behavioural result model ----------------
    int          exp_k, exp_done, exp_retry, last_done_cyc;
    bit          exp_pass, exp_idm, exp_tsm, exp_tmo, exp_busy, chk_en, prev_stall;
    logic [31:0] exp_idv = 32'h0, exp_tsv = 32'h0;

    // k is the cycle index right after the edge that launches the run.
    task automatic set_model(input int k);
        int first_good;
        exp_k = k;
        if (stuck) begin
            exp_tmo   = 1;
            exp_pass  = 0;
            exp_idm   = 0;
            exp_tsm   = 0;
            exp_retry = 0;
            exp_done  = k + TMO;
        end else begin
            exp_tmo    = 0;
            first_good = (id_err > ts_err) ? id_err : ts_err;
            if (first_good <= MAXR) begin
                exp_retry = first_good;
                exp_pass  = 1;
                exp_idm   = 0;
                exp_tsm   = 0;
            end else begin
                exp_retry = MAXR;
                exp_pass  = 0;
                exp_idm   = (MAXR < id_err);
                exp_tsm   = (MAXR < ts_err);
            end
            exp_idv  = (exp_retry < id_err) ? id_bad : EXP_ID;
            exp_tsv  = (exp_retry < ts_err) ? ts_bad : EXP_TS;
            exp_done = k + 3 + 3 * exp_retry + 2 * stall_cfg * (exp_retry + 1);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (!reset && chk_en) begin
            exp_busy = (cyc >= exp_k) && (cyc < exp_done);
            chk("done", done, 32'(cyc == exp_done));
            chk("busy", busy, 32'(exp_busy));
            if (done) last_done_cyc = cyc;
            if (avm_read) chk("address", avm_address, 32'((rd_idx - run_base) % 2));
            if (!exp_busy) chk("read_idle", avm_read, 0);
            if (prev_stall && cyc != exp_done) chk("read_hold", avm_read, 1);
            if (exp_busy) begin
                chk("pass_busy", pass, 0);
                chk("flags_busy", {id_mismatch, ts_mismatch, timeout}, 0);
            end
            if (cyc >= exp_done) begin
                chk("pass", pass, 32'(exp_pass));
                chk("id_mismatch", id_mismatch, 32'(exp_idm));
                chk("ts_mismatch", ts_mismatch, 32'(exp_tsm));
                chk("timeout", timeout, 32'(exp_tmo));
                chk("retry_count", retry_count, 32'(exp_retry));
                chk("id_value", id_value, exp_idv);
                chk("ts_value", ts_value, exp_tsv);
            end
            prev_stall = avm_read && avm_waitrequest;
        end
    end

    task automatic launch(input int ie, input int te, input int st,
                          input logic [31:0] ib, input logic [31:0] tb_);
        @(negedge clock);
        id_err    = ie;
        ts_err    = te;
        stall_cfg = st;
        id_bad    = ib;
        ts_bad    = tb_;
        run_base  = rd_idx;
        set_model(cyc + 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (cyc < exp_done + 2 && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 2000) begin
            failures++;
            checks++;
            $display("FAIL wait_done: run did not end, cyc=%0d expected done at %0d", cyc, exp_done);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stuck = 0; stall_cfg = 0;
        id_err = 0; ts_err = 0; id_bad = 32'h1; ts_bad = 32'h1;
        run_base = 0; chk_en = 0; prev_stall = 0; last_done_cyc = -1;
        exp_k = 0; exp_done = -1;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_read", avm_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_idv", id_value, 0);
        chk("rst_retry", retry_count, 0);

        // Boot run, zero wait
        set_model(1);
        reset = 1'b0;
        chk_en = 1;
        wait_done();
        chk("boot_done_cycle", 32'(last_done_cyc), 4);
        chk("boot_pass", pass, 1);
        chk("boot_retry", retry_count, 0);

        // ID wrong on every read: all retries used
        launch(99, 0, 0, 32'h1, 32'h1);
        wait_done();
        chk("idbad_latency", 32'(last_done_cyc - exp_k), 12);
        chk("idbad_pass", pass, 0);
        chk("idbad_idm", id_mismatch, 1);
        chk("idbad_tsm", ts_mismatch, 0);
        chk("idbad_retry", retry_count, 3);

        // First ID read bad, then correct
        launch(1, 0, 0, 32'hDEAD, 32'h1);
        wait_done();
        chk("once_latency", 32'(last_done_cyc - exp_k), 6);
        chk("once_pass", pass, 1);
        chk("once_retry", retry_count, 1);

        // 5 wait cycles per read, start pulsed while busy and during DONE
        launch(0, 0, 5, 32'h1, 32'h1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < exp_done) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (4) @(negedge clock);
        chk("stall_latency", 32'(last_done_cyc - exp_k), 13);
        chk("stall_pass", pass, 1);
        chk("start_in_done_ignored", busy, 0);

        // Randomized runs
        for (int n = 0; n < 30; n++) begin
            launch($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
                   $urandom | 32'h1, EXP_TS ^ ($urandom | 32'h1));
            wait_done();
        end

`ifdef SYSID_CHECK_TIMEOUT_EN
        // Waitrequest stuck: timeout abort
        stuck = 1;
        launch(0, 0, 0, 32'h1, 32'h1);
        wait_done();
        stuck = 0;
        chk("tmo_latency", 32'(last_done_cyc - exp_k), 8);
        chk("tmo_flag", timeout, 1);
        chk("tmo_pass", pass, 0);
`endif

        // Reset during RD_TS: immediate clear, no done, boot run repeats
        launch(0, 0, 0, 32'h1, 32'h1);
        @(negedge clock);
        #2;
        chk_en = 0;
        reset = 1'b1;
        #1;
        chk("mid_rst_read", avm_read, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idv", id_value, 0);
        chk("mid_rst_pass", pass, 0);
        @(negedge clock);
        stall_cfg = 0;
        id_err = 0;
        ts_err = 0;
        run_base = 0;
        prev_stall = 0;
        last_done_cyc = -1;
        exp_idv = 32'h0;
        exp_tsv = 32'h0;
        set_model(1);
        reset = 1'b0;
        chk_en = 1;
        wait_done();
        chk("reboot_done_cycle", 32'(last_done_cyc), 4);
        chk("reboot_pass", pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
